// File: rtl/down_counter.sv
// Loadable countdown counter with one-cycle underflow strobe on a decrement at zero.
// Latency: load and each accepted dec take effect on the next clk edge; underflow is same-cycle.
// Backpressure: none; dec is ignored in IDLE, load > stop > dec. Option: DOWN_COUNTER_AUTORELOAD_EN.
module down_counter #(
    parameter int  MAX_COUNT = 31,
    localparam int BIT_WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] load_val,
    input  logic                 stop,
    input  logic                 dec,
    output logic                 busy,
    output logic                 zero,
    output logic                 underflow,
    output logic [BIT_WIDTH-1:0] out
);

    localparam logic [BIT_WIDTH-1:0] MAX_VAL = BIT_WIDTH'(MAX_COUNT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] out_q, out_d;
    logic [BIT_WIDTH-1:0] sat_val;

    // Clamp the requested start value to the largest representable count.
    assign sat_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [BIT_WIDTH-1:0] reload_q;

    // Remember the last loaded value so a terminal decrement can restart the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= sat_val;
        end
    end
`endif

    // State and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Next-state, next-count and underflow strobe; load beats stop beats dec.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        underflow = 1'b0;
        if (load) begin
            out_d   = sat_val;
            state_d = S_RUN;
        end else if (stop) begin
            state_d = S_IDLE;
        end else if ((state_q == S_RUN) && dec) begin
            if (out_q != '0) begin
                out_d = out_q - BIT_WIDTH'(1);
            end else begin
                // Terminal decrement: never wrap, either restart or park at zero.
                underflow = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                out_d     = reload_q;
`else
                state_d   = S_IDLE;
`endif
            end
        end
    end

    assign busy = (state_q == S_RUN);
    assign zero = (out_q == '0);
    assign out  = out_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench: two instances (MAX_COUNT 31 and 20) driven in lockstep,
// compared every cycle against an integer reference model, plus directed scenarios.
// Honours DOWN_COUNTER_AUTORELOAD_EN when the bundle is built with it.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       stop = 1'b0;
    logic       dec = 1'b0;
    logic [4:0] load_val = '0;

    logic       busy_a, zero_a, uf_a;
    logic [4:0] out_a;
    logic       busy_b, zero_b, uf_b;
    logic [4:0] out_b;

    always #5 clk = ~clk;

    down_counter #(.MAX_COUNT(31)) dut_a (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .stop(stop), .dec(dec),
        .busy(busy_a), .zero(zero_a), .underflow(uf_a), .out(out_a)
    );

    down_counter #(.MAX_COUNT(20)) dut_b (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .stop(stop), .dec(dec),
        .busy(busy_b), .zero(zero_b), .underflow(uf_b), .out(out_b)
    );

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    // Reference model: plain integers per instance.
    int m_out[2];
    int m_rel[2];
    bit m_run[2];
    int m_max[2] = '{31, 20};
    int uf_cnt[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
    task automatic cycle(input bit r, input bit l, input logic [4:0] lv, input bit s, input bit d);
        logic [4:0] o;
        logic       b, z, u;
        bit         exp_uf;
        @(negedge clk);
        rst = r; load = l; load_val = lv; stop = s; dec = d;
        #2;
        for (int i = 0; i < 2; i++) begin
            o = (i == 0) ? out_a  : out_b;
            b = (i == 0) ? busy_a : busy_b;
            z = (i == 0) ? zero_a : zero_b;
            u = (i == 0) ? uf_a   : uf_b;
            exp_uf = m_run[i] && d && (m_out[i] == 0) && !l && !s;
            check($sformatf("out[%0d]", i), 32'(o), 32'(m_out[i]));
            check($sformatf("busy[%0d]", i), 32'(b), 32'(m_run[i]));
            check($sformatf("zero[%0d]", i), 32'(z), 32'(m_out[i] == 0));
            check($sformatf("underflow[%0d]", i), 32'(u), 32'(exp_uf));
            if (u === 1'b1) uf_cnt[i]++;
            // model update for the coming edge
            if (r) begin
                m_out[i] = 0; m_rel[i] = 0; m_run[i] = 0;
            end else if (l) begin
                m_out[i] = (int'(lv) > m_max[i]) ? m_max[i] : int'(lv);
                m_rel[i] = m_out[i];
                m_run[i] = 1;
            end else if (s) begin
                m_run[i] = 0;
            end else if (m_run[i] && d) begin
                if (m_out[i] > 0) m_out[i] = m_out[i] - 1;
                else if (AUTORELOAD) m_out[i] = m_rel[i];
                else m_run[i] = 0;
            end
        end
    endtask

    // Wait for the edge that consumes the last driven inputs, then settle.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_rel[i] = 0; m_run[i] = 0; uf_cnt[i] = 0;
        end

        // Reset, then explicit reset-state check.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        after_edge();
        check("rst_out", 32'(out_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_zero", 32'(zero_a), 1);

        // Load 5, six decrements.
        cycle(0, 1, 5'd5, 0, 0);
        after_edge();
        check("t1_load_out", 32'(out_a), 5);
        check("t1_load_busy", 32'(busy_a), 1);
        uf_cnt = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 0, 0, 1);
            after_edge();
            check("t1_dec_out", 32'(out_a), (k < 5) ? 32'(4 - k) : (AUTORELOAD ? 32'd5 : 32'd0));
        end
        check("t1_uf_count", 32'(uf_cnt[0]), 1);
        check("t1_busy_end", 32'(busy_a), 32'(AUTORELOAD));

        // Saturation: load 31 into both; 21 decrements.
        cycle(0, 1, 5'd31, 0, 0);
        after_edge();
        check("t2_sat_a", 32'(out_a), 31);
        check("t2_sat_b", 32'(out_b), 20);
        uf_cnt = '{0, 0};
        for (int k = 0; k < 21; k++) cycle(0, 0, 0, 0, 1);
        check("t2_uf_b", 32'(uf_cnt[1]), 1);
        check("t2_uf_a", 32'(uf_cnt[0]), 0);

        // Decrements while idle after reset are ignored.
        cycle(1, 0, 0, 0, 0);
        uf_cnt = '{0, 0};
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1);
        after_edge();
        check("t3_idle_out", 32'(out_a), 0);
        check("t3_idle_busy", 32'(busy_a), 0);
        check("t3_idle_uf", 32'(uf_cnt[0]), 0);

        // Load 0 then load 7 together with a terminal dec.
        cycle(0, 1, 5'd0, 0, 0);
        uf_cnt = '{0, 0};
        cycle(0, 1, 5'd7, 0, 1);
        after_edge();
        check("t4_load_out", 32'(out_a), 7);
        check("t4_load_busy", 32'(busy_a), 1);
        check("t4_no_uf", 32'(uf_cnt[0]), 0);

        // Stop beats dec; later dec ignored.
        cycle(0, 1, 5'd3, 0, 0);
        cycle(0, 0, 0, 1, 1);
        after_edge();
        check("t5_stop_out", 32'(out_a), 3);
        check("t5_stop_busy", 32'(busy_a), 0);
        cycle(0, 0, 0, 0, 1);
        after_edge();
        check("t5_idle_dec_out", 32'(out_a), 3);

        // Reset mid-count with dec held.
        cycle(0, 1, 5'd4, 0, 0);
        cycle(1, 0, 0, 0, 1);
        after_edge();
        check("t6_rst_out", 32'(out_a), 0);
        check("t6_rst_busy", 32'(busy_a), 0);
        check("t6_rst_zero", 32'(zero_a), 1);
        uf_cnt = '{0, 0};
        cycle(0, 0, 0, 0, 1);
        check("t6_no_uf", 32'(uf_cnt[0]), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) == 0,
                  5'($urandom),
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable countdown counter, the decrementing counterpart of the team's incrementing event counter. A consumer loads a start value, decrements on qualifying events, and gets a one-cycle underflow strobe when a decrement arrives at zero. Used for credit and budget tracking and for tile/row countdowns in the accelerator datapath; `underflow` feeds the same kind of wrap/advance logic that the up-counter's `overflow` feeds.

## Interface
- `MAX_COUNT`, 31: largest value the counter can hold.
- `BIT_WIDTH`, `$clog2(MAX_COUNT+1)` (localparam, not overridable): width of count and load value.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `load`, input, 1: load `load_val` and start counting.
- `load_val`, input, `BIT_WIDTH`: start value; saturated to `MAX_COUNT`.
- `stop`, input, 1: abort the countdown; return to IDLE and hold `out`.
- `dec`, input, 1: decrement request; effective only while running.
- `busy`, output, 1: registered; 1 while in RUN.
- `zero`, output, 1: combinational, `out == 0`.
- `underflow`, output, 1: combinational strobe; decrement accepted at zero.
- `out`, output, `BIT_WIDTH`: registered current count.

## Operation
- States: IDLE (`busy=0`) and RUN (`busy=1`).
- Priority per cycle: `rst` > `load` > `stop` > `dec`.
- Saturation: `sat_val = (load_val > MAX_COUNT) ? MAX_COUNT : load_val`.
- `load`, any state:
  - `out <= sat_val`
  - `reload_val <= sat_val`
  - state `<=` RUN
- `stop` without `load`: state `<=` IDLE, `out` holds.
- RUN, `dec`, `out != 0`: `out <= out - 1`, stay in RUN.
- RUN, `dec`, `out == 0`:
  - `underflow = 1` in that cycle.
  - Next state per Configuration; never wraps to `MAX_COUNT`.
- IDLE, `dec`: ignored. `out` holds and `underflow = 0`.
- `underflow = (state==RUN) & dec & (out==0) & !load & !stop`.
- A `load` or `stop` in the same cycle as a terminal `dec` suppresses `underflow`.
- Loading 0 is legal: enter RUN at 0, and the first `dec` underflows.
- Arithmetic is unsigned, `BIT_WIDTH` bits. The decrement is only performed when `out != 0`, so there is no borrow.

## Timing
- Reset values:
  - `out = 0`
  - `busy = 0`
  - state = IDLE
  - `reload_val = 0`
  - `zero = 1`
  - `underflow = 0`
- Load latency 1 cycle: `load` high at edge N gives `out = sat_val` and `busy = 1` after edge N.
- Decrement latency 1 cycle per accepted `dec`.
- `underflow` asserts in the same cycle as the qualifying `dec`, before the edge. It is high exactly one cycle per terminal `dec`.
- `rst` mid-count: the next edge forces all reset values regardless of other inputs.
- `busy` deasserts the cycle after a terminal `dec` or `stop` (non-autoreload).

## Configuration
- Macro: `DOWN_COUNTER_AUTORELOAD_EN`.
- Defined: a terminal `dec` in RUN sets `out <= reload_val` and the block stays in RUN (`busy` remains 1). This gives a periodic strobe every `reload_val+1` accepted decrements.
- Undefined: a terminal `dec` in RUN sets state `<=` IDLE and `out` stays 0. `reload_val` is not implemented; the register and its logic are compiled out.

## Test plan
- Reset, then `load_val=5` with `load`, then 6 consecutive `dec` -> `out` goes 5,4,3,2,1,0. `underflow` is high only on the 6th `dec`. Without the macro `busy=0` after; with the macro `out=5` and `busy=1`.
- `MAX_COUNT=20` (`BIT_WIDTH=5`), `load_val=31` -> `out=20`. Then 21 `dec` -> exactly one `underflow`.
- `dec` pulses while IDLE after reset -> `out=0`, `underflow=0`, `busy=0` throughout.
- `out=0` in RUN with `load=1`, `load_val=7` and `dec=1` in the same cycle -> `underflow=0`, next `out=7`, `busy=1`.
- `out=3` in RUN, `stop=1` with `dec=1` -> next `out=3`, `busy=0`. Later `dec` is ignored.
- `out=4` in RUN with `dec` held, assert `rst` for one cycle -> next `out=0`, `busy=0`, `zero=1`. A subsequent `dec` produces no `underflow`.
